mem_ram_bridge: RTL and testbench

//  Upstream neighbour of the physical-memory/serial mapping block: converts MEM-stage load/store requests into held ram2_* bus cycles.

---
 rtl/mem_ram_bridge.sv | 244 ++++++++++++++++++++++++
 tb/tb_mem_ram_bridge.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ram_bridge.sv
`default_nettype none
// ============================================================================
// Module   : mem_ram_bridge
// Purpose  : Turns MEM-stage load/store requests into held, multi-cycle ram2_*
//            bus cycles with byte enables, load alignment and stall control.
// Revision : 1.0  initial release
// ============================================================================
module mem_ram_bridge #(
  parameter int RD_WAIT     = 2,
  parameter int WR_WAIT     = 2,
  parameter int WR_RECOVERY = 1
) (
  input  logic        clk_50M,
  input  logic        rst,
  input  logic        mem_req_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  input  logic        mem_wr_i,
  input  logic [1:0]  mem_size_i,
  input  logic        mem_signed_i,
  output logic [31:0] mem_rdata_o,
  output logic        mem_ack_o,
  output logic        mem_err_o,
  output logic        stall_req_o,
  output logic        base_conflict_o,
  output logic [31:0] ram2_addr_o,
  output logic [31:0] ram2_data_o,
  output logic        ram2_we_o,
  output logic [3:0]  ram2_sel_o,
  output logic        ram2_ce_o,
  input  logic [31:0] ram2_data_i
);

  localparam logic [3:0] c_RD_LOAD  = 4'(RD_WAIT - 1);
  localparam logic [3:0] c_WR_LOAD  = 4'(WR_WAIT - 1);
  localparam logic [3:0] c_REC_LOAD = 4'(WR_RECOVERY - 1);
  localparam bit         c_HAS_REC  = (WR_RECOVERY != 0);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RECOV  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // latched request
  logic [1:0]  r_lane;
  logic [1:0]  r_size;
  logic        r_wr;
  logic        r_signed;
  logic        r_ser;
  logic        r_base;
  logic        r_err;
  logic [3:0]  r_cnt;
  logic [31:0] r_rdata;

  // registered bus
  logic [31:0] r_bus_addr;
  logic [31:0] r_bus_data;
  logic        r_bus_we;
  logic [3:0]  r_bus_sel;
  logic        r_bus_ce;

  // request decode
  logic        w_is_word;
  logic        w_is_half;
  logic        w_is_base;
  logic        w_is_ext;
  logic        w_is_ser;
  logic        w_misal;
  logic        w_bad;
  logic [3:0]  w_cnt_init;
  logic [3:0]  w_st_sel;
  logic [31:0] w_st_data;
  logic        w_last;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ld;

  assign w_is_word = mem_size_i[1];
  assign w_is_half = (mem_size_i == 2'b01);
  assign w_is_base = (mem_addr_i[31:22] == 10'h200);
  assign w_is_ext  = (mem_addr_i[31:22] == 10'h201);
  // the serial registers only answer word accesses; anything narrower is unmapped
  assign w_is_ser  = w_is_word &&
                     ((mem_addr_i == 32'hBFD0_03F8) || (mem_addr_i == 32'hBFD0_03FC));
  assign w_misal   = (w_is_half && mem_addr_i[0]) ||
                     (w_is_word && (mem_addr_i[1:0] != 2'b00));
  assign w_bad     = w_misal || !(w_is_base || w_is_ext || w_is_ser);
  assign w_cnt_init = w_is_ser ? 4'd0 : (mem_wr_i ? c_WR_LOAD : c_RD_LOAD);
  assign w_last    = (r_cnt == 4'd0);

  always_comb begin
    w_st_sel  = 4'b0000;
    w_st_data = mem_wdata_i;
    case (mem_size_i)
      2'b00: begin
        w_st_sel  = ~(4'b0001 << mem_addr_i[1:0]);
        w_st_data = {4{mem_wdata_i[7:0]}};
      end
      2'b01: begin
        w_st_sel  = mem_addr_i[1] ? 4'b0011 : 4'b1100;
        w_st_data = {2{mem_wdata_i[15:0]}};
      end
      default: begin
        w_st_sel  = 4'b0000;
        w_st_data = mem_wdata_i;
      end
    endcase
  end

  always_comb begin
    w_byte = ram2_data_i[{r_lane, 3'b000} +: 8];
    w_half = r_lane[1] ? ram2_data_i[31:16] : ram2_data_i[15:0];
    w_ld   = ram2_data_i;
    case (r_size)
      2'b00:   w_ld = {{24{r_signed & w_byte[7]}}, w_byte};
      2'b01:   w_ld = {{16{r_signed & w_half[15]}}, w_half};
      default: w_ld = ram2_data_i;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (mem_req_i) begin
          w_state_next = w_bad ? S_DONE : S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (w_last) begin
          w_state_next = (r_wr && !r_ser && c_HAS_REC) ? S_RECOV : S_DONE;
        end
      end
      S_RECOV: begin
        if (w_last) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_50M) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk_50M) begin
    if (rst) begin
      r_lane   <= 2'b00;
      r_size   <= 2'b00;
      r_wr     <= 1'b0;
      r_signed <= 1'b0;
      r_ser    <= 1'b0;
      r_base   <= 1'b0;
      r_err    <= 1'b0;
      r_cnt    <= 4'd0;
      r_rdata  <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (mem_req_i) begin
            r_lane   <= mem_addr_i[1:0];
            r_size   <= mem_size_i;
            r_wr     <= mem_wr_i;
            r_signed <= mem_signed_i;
            r_ser    <= w_is_ser;
            r_base   <= w_is_base && !w_bad;
            r_err    <= w_bad;
            r_cnt    <= w_cnt_init;
            if (w_bad) begin
              r_rdata <= 32'd0;
            end
          end
        end
        S_ACCESS: begin
          if (w_last) begin
            r_cnt <= c_REC_LOAD;
            if (!r_wr) begin
              r_rdata <= w_ld;
            end
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_RECOV: begin
          if (!w_last) begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // bus registers follow the next state so they are valid for the whole phase
  always_ff @(posedge clk_50M) begin
    if (rst) begin
      r_bus_ce   <= 1'b0;
      r_bus_we   <= 1'b1;
      r_bus_sel  <= 4'b1111;
      r_bus_addr <= 32'd0;
      r_bus_data <= 32'd0;
    end else if (r_state == S_IDLE && w_state_next == S_ACCESS) begin
      r_bus_ce   <= 1'b1;
      r_bus_we   <= !mem_wr_i;
      r_bus_sel  <= mem_wr_i ? w_st_sel : 4'b0000;
      r_bus_addr <= {mem_addr_i[31:2], 2'b00};
      r_bus_data <= mem_wr_i ? w_st_data : 32'd0;
    end else if (w_state_next == S_RECOV) begin
      r_bus_we   <= 1'b1;
    end else if (w_state_next == S_DONE || w_state_next == S_IDLE) begin
      r_bus_ce   <= 1'b0;
      r_bus_we   <= 1'b1;
      r_bus_sel  <= 4'b1111;
      r_bus_addr <= 32'd0;
      r_bus_data <= 32'd0;
    end
  end

  assign ram2_ce_o   = r_bus_ce;
  assign ram2_we_o   = r_bus_we;
  assign ram2_sel_o  = r_bus_sel;
  assign ram2_addr_o = r_bus_addr;
  assign ram2_data_o = r_bus_data;

  assign mem_rdata_o     = r_rdata;
  assign mem_ack_o       = (r_state == S_DONE);
  assign mem_err_o       = (r_state == S_DONE) && r_err;
  assign stall_req_o     = ((r_state == S_IDLE) && mem_req_i) ||
                           (r_state == S_ACCESS) || (r_state == S_RECOV);
  assign base_conflict_o = ((r_state == S_ACCESS) || (r_state == S_RECOV)) && r_base;

endmodule
`default_nettype wire

// File: tb/tb_mem_ram_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_ram_bridge
// Purpose  : Randomised scoreboard bench for mem_ram_bridge.
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_ram_bridge;

  localparam int RD_WAIT     = 2;
  localparam int WR_WAIT     = 2;
  localparam int WR_RECOVERY = 1;

  logic        clk_50M = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req_i = 1'b0;
  logic [31:0] mem_addr_i = 32'd0;
  logic [31:0] mem_wdata_i = 32'd0;
  logic        mem_wr_i = 1'b0;
  logic [1:0]  mem_size_i = 2'b00;
  logic        mem_signed_i = 1'b0;
  logic [31:0] mem_rdata_o;
  logic        mem_ack_o;
  logic        mem_err_o;
  logic        stall_req_o;
  logic        base_conflict_o;
  logic [31:0] ram2_addr_o;
  logic [31:0] ram2_data_o;
  logic        ram2_we_o;
  logic [3:0]  ram2_sel_o;
  logic        ram2_ce_o;
  logic [31:0] ram2_data_i = 32'd0;

  mem_ram_bridge #(
    .RD_WAIT    (RD_WAIT),
    .WR_WAIT    (WR_WAIT),
    .WR_RECOVERY(WR_RECOVERY)
  ) dut (
    .clk_50M        (clk_50M),
    .rst            (rst),
    .mem_req_i      (mem_req_i),
    .mem_addr_i     (mem_addr_i),
    .mem_wdata_i    (mem_wdata_i),
    .mem_wr_i       (mem_wr_i),
    .mem_size_i     (mem_size_i),
    .mem_signed_i   (mem_signed_i),
    .mem_rdata_o    (mem_rdata_o),
    .mem_ack_o      (mem_ack_o),
    .mem_err_o      (mem_err_o),
    .stall_req_o    (stall_req_o),
    .base_conflict_o(base_conflict_o),
    .ram2_addr_o    (ram2_addr_o),
    .ram2_data_o    (ram2_data_o),
    .ram2_we_o      (ram2_we_o),
    .ram2_sel_o     (ram2_sel_o),
    .ram2_ce_o      (ram2_ce_o),
    .ram2_data_i    (ram2_data_i)
  );

  always #10 clk_50M = ~clk_50M;

  int cyc = 0;
  always @(posedge clk_50M) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          t;
    int          lat;
    logic        err;
    logic        chk_rdata;
    logic [31:0] rdata;
    int          ce_n;
    int          we_n;
    int          base_n;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // expected behaviour straight from the address map, lane and timing rules
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] wd, input logic wr,
                                 input logic [1:0] sz, input logic sg, input logic [31:0] rd,
                                 input int t);
    exp_t        e;
    logic        word, half, base, ext, ser, mis;
    int          lane;
    logic [31:0] v;
    word = (sz >= 2'd2);
    half = (sz == 2'd1);
    base = (a >= 32'h8000_0000) && (a <= 32'h803F_FFFF);
    ext  = (a >= 32'h8040_0000) && (a <= 32'h807F_FFFF);
    ser  = word && (a == 32'hBFD0_03F8 || a == 32'hBFD0_03FC);
    lane = int'(a[1:0]);
    mis  = (half && (lane % 2 != 0)) || (word && lane != 0);
    e.t = t;
    e.err = mis || !(base || ext || ser);
    e.addr = a & 32'hFFFF_FFFC;
    e.chk_rdata = e.err || !wr;
    e.rdata = 32'd0;
    e.sel = 4'b0000;
    e.data = 32'd0;
    if (e.err) begin
      e.lat = 1; e.ce_n = 0; e.we_n = 0;
    end else if (ser) begin
      e.lat = 2; e.ce_n = 1; e.we_n = wr ? 1 : 0;
    end else if (wr) begin
      e.lat = WR_WAIT + WR_RECOVERY + 1; e.ce_n = WR_WAIT + WR_RECOVERY; e.we_n = WR_WAIT;
    end else begin
      e.lat = RD_WAIT + 1; e.ce_n = RD_WAIT; e.we_n = 0;
    end
    e.base_n = (base && !e.err) ? e.ce_n : 0;
    if (wr) begin
      if (word) begin
        e.sel = 4'b0000; e.data = wd;
      end else if (half) begin
        e.sel = (lane >= 2) ? 4'b0011 : 4'b1100;
        e.data = (wd & 32'hFFFF) * 32'h0001_0001;
      end else begin
        e.sel = 4'hF - 4'(1 << lane);
        e.data = (wd & 32'hFF) * 32'h0101_0101;
      end
    end else if (!e.err) begin
      if (word) begin
        e.rdata = rd;
      end else if (half) begin
        v = (rd >> (16 * (lane / 2))) & 32'hFFFF;
        if (sg && v >= 32'h8000) v = v | 32'hFFFF_0000;
        e.rdata = v;
      end else begin
        v = (rd >> (8 * lane)) & 32'hFF;
        if (sg && v >= 32'h80) v = v | 32'hFFFF_FF00;
        e.rdata = v;
      end
    end
    return e;
  endfunction

  // monitor: accumulates bus activity, checks it against the queue head on ack
  int          st_n, ce_n, we_n, base_n;
  logic        hold_bad;
  logic [3:0]  cap_sel;
  logic [31:0] cap_addr, cap_data;

  task automatic mon_clear();
    st_n = 0; ce_n = 0; we_n = 0; base_n = 0; hold_bad = 1'b0;
    cap_sel = 4'hF; cap_addr = 32'd0; cap_data = 32'd0;
  endtask

  initial mon_clear();

  always @(negedge clk_50M) begin
    exp_t e;
    if (rst) begin
      mon_clear();
    end else begin
      if (stall_req_o) st_n++;
      if (base_conflict_o) base_n++;
      if (ram2_ce_o) begin
        ce_n++;
        if (!ram2_we_o) we_n++;
        if (ce_n == 1) begin
          cap_sel = ram2_sel_o; cap_addr = ram2_addr_o; cap_data = ram2_data_o;
        end else if (cap_sel !== ram2_sel_o || cap_addr !== ram2_addr_o ||
                     cap_data !== ram2_data_o) begin
          hold_bad = 1'b1;
        end
      end
      if (mem_ack_o) begin
        if (q.size() == 0) begin
          chk("unexpected_ack", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk("ack_latency", cyc - e.t, e.lat);
          chk("err", {31'd0, mem_err_o}, {31'd0, e.err});
          chk("stall_cycles", st_n, e.lat);
          chk("ce_cycles", ce_n, e.ce_n);
          chk("we_low_cycles", we_n, e.we_n);
          chk("base_conflict_cycles", base_n, e.base_n);
          if (e.ce_n > 0) begin
            chk("bus_sel", {28'd0, cap_sel}, {28'd0, e.sel});
            chk("bus_addr", cap_addr, e.addr);
            chk("bus_data", cap_data, e.data);
            chk("bus_held", {31'd0, hold_bad}, 32'd0);
          end
          if (e.chk_rdata) chk("rdata", mem_rdata_o, e.rdata);
        end
        mon_clear();
      end
    end
  end

  // issue one request at posedge+1 and hold it until ack
  task automatic do_txn(input logic [31:0] a, input logic [31:0] wd, input logic wr,
                        input logic [1:0] sz, input logic sg, input logic [31:0] rd);
    int n;
    mem_addr_i = a; mem_wdata_i = wd; mem_wr_i = wr; mem_size_i = sz;
    mem_signed_i = sg; ram2_data_i = rd; mem_req_i = 1'b1;
    q.push_back(model(a, wd, wr, sz, sg, rd, cyc));
    n = 0;
    do begin
      @(negedge clk_50M);
      n++;
    end while (!mem_ack_o && n < 40);
    if (!mem_ack_o) begin
      chk("ack_timeout", 32'd0, 32'd1);
      q.delete();
      mem_req_i = 1'b0;
      rst = 1'b1;
      @(posedge clk_50M); #1;
      rst = 1'b0;
    end
    @(posedge clk_50M); #1;
    mem_req_i = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    logic [1:0]  sz;
    int          r;

    repeat (3) @(posedge clk_50M);
    #1 rst = 1'b0;
    @(negedge clk_50M);
    chk("rst_ce", {31'd0, ram2_ce_o}, 32'd0);
    chk("rst_we", {31'd0, ram2_we_o}, 32'd1);
    chk("rst_sel", {28'd0, ram2_sel_o}, 32'hF);
    chk("rst_addr", ram2_addr_o, 32'd0);
    chk("rst_data", ram2_data_o, 32'd0);
    chk("rst_ack", {31'd0, mem_ack_o}, 32'd0);
    chk("rst_err", {31'd0, mem_err_o}, 32'd0);
    chk("rst_rdata", mem_rdata_o, 32'd0);
    chk("rst_stall", {31'd0, stall_req_o}, 32'd0);
    chk("rst_base", {31'd0, base_conflict_o}, 32'd0);
    @(posedge clk_50M); #1;

    // directed cases
    do_txn(32'h8040_0010, 32'd0, 1'b0, 2'b10, 1'b0, 32'hDEAD_BEEF);
    do_txn(32'h8000_0003, 32'h0000_00A5, 1'b1, 2'b00, 1'b0, 32'd0);
    do_txn(32'h8040_0001, 32'd0, 1'b0, 2'b00, 1'b1, 32'h0000_8000);
    do_txn(32'h8040_0001, 32'd0, 1'b0, 2'b00, 1'b0, 32'h0000_8000);
    do_txn(32'hBFD0_03F8, 32'h0000_0041, 1'b1, 2'b10, 1'b0, 32'd0);
    do_txn(32'h8040_0001, 32'd0, 1'b0, 2'b01, 1'b0, 32'h1234_5678);
    do_txn(32'h0000_1000, 32'd0, 1'b0, 2'b10, 1'b0, 32'h1234_5678);

    // reset in the middle of a store: bus idles, no ack appears
    mem_addr_i = 32'h8000_0100; mem_wdata_i = 32'h1111_2222; mem_wr_i = 1'b1;
    mem_size_i = 2'b10; mem_req_i = 1'b1;
    @(posedge clk_50M); #1;
    @(posedge clk_50M); #1;
    rst = 1'b1; mem_req_i = 1'b0;
    @(posedge clk_50M); #1;
    rst = 1'b0;
    @(negedge clk_50M);
    chk("abort_ce", {31'd0, ram2_ce_o}, 32'd0);
    chk("abort_we", {31'd0, ram2_we_o}, 32'd1);
    chk("abort_sel", {28'd0, ram2_sel_o}, 32'hF);
    chk("abort_stall", {31'd0, stall_req_o}, 32'd0);
    repeat (5) begin
      chk("abort_no_ack", {31'd0, mem_ack_o}, 32'd0);
      @(negedge clk_50M);
    end
    @(posedge clk_50M); #1;
    do_txn(32'h8000_0100, 32'h3333_4444, 1'b1, 2'b10, 1'b0, 32'd0);
    do_txn(32'h8000_0100, 32'd0, 1'b0, 2'b01, 1'b1, 32'h8001_7FFF);

    // randomised traffic including region edges and serial registers
    for (int i = 0; i < 300; i++) begin
      r = int'($urandom_range(0, 9));
      sz = 2'($urandom_range(0, 3));
      case (r)
        0, 1, 2, 3: a = 32'h8000_0000 + ($urandom & 32'h003F_FFFF);
        4, 5, 6:    a = 32'h8040_0000 + ($urandom & 32'h003F_FFFF);
        7: begin
          a = $urandom_range(0, 1) ? 32'hBFD0_03F8 : 32'hBFD0_03FC;
          if ($urandom_range(0, 3) != 0) sz = 2'b10;
        end
        8:       a = $urandom;
        default: a = ($urandom_range(0, 1) ? 32'h803F_FFFC : 32'h807F_FFFC) +
                     32'($urandom_range(0, 7));
      endcase
      do_txn(a, $urandom, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), $urandom);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk_50M); #1;
      end
    end

    repeat (4) @(negedge clk_50M);
    chk("queue_drained", q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
